fast_meta_parser: RTL and testbench
===================================

# fast_meta_parser

Parses the 134-bit FAST packet stream entering the gateway and builds the 209-bit connection metadata word consumed by the connection-tracking core (`metadata_in_valid`/`metadata_in`, gated by its `ready`). Packet lines are forwarded unchanged with one cycle of latency. Metadata words are queued in a small FIFO so that connection-core stalls do not back-pressure the packet path. A metadata word is dropped, and counted, only when that FIFO is full.

## Interface
- `w_pkt`, 134: FAST line width. [133:132] flag: 01 head, 11 body, 10 tail. [131:128] valid bytes minus 1. [127:0] data, byte 0 at [127:120].
- `w_meta`, 209: metadata width.
- `d_fifo`, 2: log2 of the metadata FIFO depth (depth 4).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `pkt_in_wr` in 1: input line valid.
- `pkt_in` in 134: input line.
- `pkt_out_wr` out 1: forwarded line valid.
- `pkt_out` out 134: forwarded line.
- `meta_ready` in 1: connection core ready; connect to its `ready` output.
- `metadata_out_valid` out 1: single-cycle metadata strobe.
- `metadata_out` out 209: metadata word.
- `cnt_pkt` out 32: IPv4 packets parsed.
- `cnt_meta_drop` out 16: metadata dropped because the FIFO was full.
- `cnt_malformed` out 16: aborted or truncated packets.

## Operation
- Line 0 (head) is FAST metadata. Line 1 onward carries Ethernet bytes 0–15, 16–31, and so on.
- The hit bit is taken from line 0, data[127].
- Metadata layout, MSB first:
  - [208] hit
  - [207:104] key = {srcIP32, dstIP32, sport16, dport16, proto8}
  - [103:88] content length
  - [87:80] TCP flags
  - [79:48] seq
  - [47:16] ack
  - [15:0] window
- Byte offsets used, with no VLAN: ethertype 12–13, IP total length 16–17, proto 23, src IP 26–29, dst IP 30–33, L4 header at 34.
  - TCP: data offset nibble at byte 46, flags byte 47, window 48–49.
- Packet type handling:
  - Ethertype other than 0x0800: no metadata; the packet is only forwarded.
  - IPv4 with IHL != 5: no metadata; no counter changes.
- Content length, computed modulo 2^16:
  - TCP (proto 6): total − 20 − 4·doff.
  - UDP (proto 17): total − 28. Flags, seq, ack and window are zero.
  - Other protocols: total − 20. Ports, flags, seq, ack and window are zero.
- FSM states and transitions:
  - IDLE: head → L1.
  - L1: next line → L2.
  - L2: next line → L3.
  - L3: next line → L4.
  - L4: on capture → commit, then WAIT_TAIL. If that same line is the tail → IDLE.
  - WAIT_TAIL: tail → IDLE.
- Commit: a qualifying IPv4 packet increments `cnt_pkt` and pushes one word into the FIFO. If the FIFO is full, the word is dropped and `cnt_meta_drop` increments.
- Error cases:
  - Tail in L1–L3 (truncated): no push; `cnt_malformed`++; → IDLE.
  - Head in any state other than IDLE: `cnt_malformed`++; the current parse is abandoned; the new head is treated as line 0 → L1.
  - A non-head line received in IDLE is forwarded only.
- FIFO pop: when the FIFO is non-empty and `meta_ready` = 1, assert `metadata_out_valid` for one cycle with the head word, and pop.
- A push and a pop in the same cycle with a full FIFO is accepted, with no drop.
- All counters saturate at their maximum value.

## Timing
- Reset values: `pkt_out_wr` = 0, `pkt_out` = 0, `metadata_out_valid` = 0, `metadata_out` = 0, all counters = 0, FSM = IDLE, FIFO empty.
- Packet path: `pkt_out_wr`/`pkt_out` equal `pkt_in_wr`/`pkt_in` delayed by exactly 1 cycle. There is no bubble and no backpressure.
- Metadata latency with an empty FIFO and `meta_ready` = 1: `metadata_out_valid` rises 2 cycles after the line-4 input cycle (1 cycle for commit/push, 1 cycle for the registered pop).
- Throughput: one pop per cycle maximum. Consecutive pops are allowed while `meta_ready` stays high.
- Idle gaps (`pkt_in_wr` = 0) between lines do not change the FSM state.
- Reset asserted mid-packet: the FSM, FIFO and counters clear immediately. Any remaining lines of that packet arriving in IDLE are forwarded only.

## Configuration
- `FAST_PARSER_VLAN_EN`
  - Defined: ethertype 0x8100 at bytes 12–13 means one 802.1Q tag. The inner ethertype is at 16–17 and every later offset shifts by +4 (the window ends at byte 53, still in line 4).
  - Undefined: 0x8100 is treated as non-IPv4 and no metadata is produced.

## Test plan
- TCP SYN: hit = 1, 10.0.0.1:1234 → 10.0.0.2:80, total 40, doff 5, flags 0x02, seq 0x11111111, window 0xFFFF.
  - Expect `metadata_out` = {1, 0x0A000001, 0x0A000002, 0x04D2, 0x0050, 0x06, 0x0000, 0x02, 0x11111111, 0, 0xFFFF}.
  - Expect `cnt_pkt` = 1 and the valid strobe 2 cycles after line 4.
- UDP, total 100: content length 72, flags/seq/ack/window zero. ARP frame (ethertype 0x0806): no metadata; forwarded unchanged with 1-cycle latency.
- `meta_ready` held 0 while 6 TCP packets are sent: 4 words are queued and `cnt_meta_drop` = 2. Then `meta_ready` = 1: 4 strobes on consecutive cycles, in arrival order.
- Tail on line 2, followed by a head arriving in L3: `cnt_malformed` = 2, no metadata. The following good packet parses correctly.
- Reset pulled low while in L3: all outputs and counters are 0. Remaining lines are forwarded and no metadata is emitted.
- With `FAST_PARSER_VLAN_EN` defined: a VLAN-tagged TCP packet gives the same metadata as the untagged case. With it undefined: no metadata.

Source files
------------

// File: rtl/fast_meta_parser.sv
// -----------------------------------------------------------------------------
// fast_meta_parser
//
// Watches the FAST packet stream on its way into the gateway. Each line is
// forwarded unchanged one cycle later. For IPv4 packets it also builds one
// 209-bit connection-metadata word for the connection-tracking core.
//
// Metadata words wait in a small FIFO, so stalls in the connection core never
// back-pressure the packet path. A word is dropped, and counted, only when
// that FIFO is full.
//
// Line 0 of a packet is FAST metadata; its data[127] is the hit bit.
// Lines 1..4 carry Ethernet bytes 0..63. Everything the metadata word needs
// lies within the first 64 bytes, so the word is assembled from the stored
// lines 1..3 plus line 4 while line 4 is on the input. It is pushed into the
// FIFO at the clock edge that accepts line 4.
//
// Optional build macro:
//   FAST_PARSER_VLAN_EN - when defined, ethertype 0x8100 means one 802.1Q tag.
//                         Every later header field then sits 4 bytes further
//                         on. When undefined, tagged frames are non-IPv4 and
//                         produce no metadata.
//
// Ports:
//   clk                 in   single clock
//   reset               in   asynchronous, active-low
//   pkt_in_wr/pkt_in    in   input FAST line: [133:132] flag (01 head,
//                            11 body, 10 tail), [131:128] bytes-1, [127:0] data
//   pkt_out_wr/pkt_out  out  input line delayed by exactly one cycle
//   meta_ready          in   connection core ready
//   metadata_out_valid  out  one-cycle strobe per metadata word
//   metadata_out        out  {hit, key104, content_len16, flags8, seq32,
//                            ack32, window16}
//   cnt_pkt             out  IPv4 packets committed (saturating)
//   cnt_meta_drop       out  words dropped on a full FIFO (saturating)
//   cnt_malformed       out  truncated or aborted packets (saturating)
// -----------------------------------------------------------------------------
module fast_meta_parser #(
  parameter int W_PKT  = 134,
  parameter int W_META = 209,
  parameter int D_FIFO = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_in_wr,
  input  logic [W_PKT-1:0]  pkt_in,
  output logic              pkt_out_wr,
  output logic [W_PKT-1:0]  pkt_out,
  input  logic              meta_ready,
  output logic              metadata_out_valid,
  output logic [W_META-1:0] metadata_out,
  output logic [31:0]       cnt_pkt,
  output logic [15:0]       cnt_meta_drop,
  output logic [15:0]       cnt_malformed
);

  localparam int DEPTH = 1 << D_FIFO;
  localparam int CW    = D_FIFO + 1;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
  localparam logic [D_FIFO-1:0] PTR_ONE  = D_FIFO'(1);

  // Each state names the line expected next.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_L1   = 3'd1;
  localparam logic [2:0] S_L2   = 3'd2;
  localparam logic [2:0] S_L3   = 3'd3;
  localparam logic [2:0] S_L4   = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  // Byte extraction from the 64-byte frame window (byte 0 at [511:504]).
  function automatic logic [7:0] fld8(input logic [511:0] f, input int b);
    return f[511-8*b -: 8];
  endfunction

  function automatic logic [15:0] fld16(input logic [511:0] f, input int b);
    return f[511-8*b -: 16];
  endfunction

  function automatic logic [31:0] fld32(input logic [511:0] f, input int b);
    return f[511-8*b -: 32];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic [2:0]   state_q, state_d;
  logic         hit_q;
  logic [127:0] l1_q, l2_q, l3_q;

  logic              pkt_out_wr_q;
  logic [W_PKT-1:0]  pkt_out_q;
  logic              meta_vld_q;
  logic [W_META-1:0] meta_q;
  logic [31:0]       cnt_pkt_q;
  logic [15:0]       cnt_drop_q;
  logic [15:0]       cnt_malf_q;

  logic [W_META-1:0] mem_q [DEPTH];
  logic [D_FIFO-1:0] wp_q, rp_q;
  logic [CW-1:0]     fcnt_q;

  logic is_head, is_tail;
  assign is_head = (pkt_in[W_PKT-1 -: 2] == 2'b01);
  assign is_tail = (pkt_in[W_PKT-1 -: 2] == 2'b10);

  // ---- Stage: field extraction while line 4 is on the input ----
  logic [511:0] frame, frame_n;
  assign frame = {l1_q, l2_q, l3_q, pkt_in[127:0]};

`ifdef FAST_PARSER_VLAN_EN
  // Sliding the window left by the tag length puts every tagged field at its
  // untagged offset. The window ends at byte 53, still inside line 4.
  assign frame_n = (fld16(frame, 12) == 16'h8100) ? (frame << 32) : frame;
`else
  assign frame_n = frame;
`endif

  logic [15:0] ethertype, total, clen, sport, dport, win;
  logic [7:0]  vihl_b, proto, doff_b, flags;
  logic [31:0] src_ip, dst_ip, seq, ack;
  logic        qualify;
  logic [W_META-1:0] meta_word;

  assign ethertype = fld16(frame_n, 12);
  assign vihl_b    = fld8(frame_n, 14);
  assign total     = fld16(frame_n, 16);
  assign proto     = fld8(frame_n, 23);
  assign src_ip    = fld32(frame_n, 26);
  assign dst_ip    = fld32(frame_n, 30);
  assign doff_b    = fld8(frame_n, 46);
  assign qualify   = (ethertype == 16'h0800) && (vihl_b[3:0] == 4'd5);

  // Fields that do not exist for a protocol are forced to zero; the content
  // length subtracts that protocol's header sizes (mod 2^16).
  always_comb begin
    sport = fld16(frame_n, 34);
    dport = fld16(frame_n, 36);
    seq   = fld32(frame_n, 38);
    ack   = fld32(frame_n, 42);
    flags = fld8(frame_n, 47);
    win   = fld16(frame_n, 48);
    clen  = total - 16'd20;
    if (proto == 8'd6) begin
      clen = total - 16'd20 - {10'd0, doff_b[7:4], 2'b00};
    end else begin
      flags = 8'd0;
      seq   = 32'd0;
      ack   = 32'd0;
      win   = 16'd0;
      if (proto == 8'd17) begin
        clen = total - 16'd28;
      end else begin
        sport = 16'd0;
        dport = 16'd0;
      end
    end
  end

  assign meta_word = {hit_q, src_ip, dst_ip, sport, dport, proto,
                      clen, flags, seq, ack, win};

  // ---- Stage: line sequencing ----
  logic ld_hit, ld1, ld2, ld3, commit, malformed;

  always_comb begin
    state_d   = state_q;
    ld_hit    = 1'b0;
    ld1       = 1'b0;
    ld2       = 1'b0;
    ld3       = 1'b0;
    commit    = 1'b0;
    malformed = 1'b0;
    if (pkt_in_wr) begin
      if (is_head) begin
        // A head always restarts the parse; outside IDLE it aborts one.
        malformed = (state_q != S_IDLE);
        ld_hit    = 1'b1;
        state_d   = S_L1;
      end else begin
        case (state_q)
          S_L1: begin
            if (is_tail) begin
              malformed = 1'b1;
              state_d   = S_IDLE;
            end else begin
              ld1     = 1'b1;
              state_d = S_L2;
            end
          end
          S_L2: begin
            if (is_tail) begin
              malformed = 1'b1;
              state_d   = S_IDLE;
            end else begin
              ld2     = 1'b1;
              state_d = S_L3;
            end
          end
          S_L3: begin
            if (is_tail) begin
              malformed = 1'b1;
              state_d   = S_IDLE;
            end else begin
              ld3     = 1'b1;
              state_d = S_L4;
            end
          end
          S_L4: begin
            commit  = qualify;
            state_d = is_tail ? S_IDLE : S_WAIT;
          end
          S_WAIT: begin
            if (is_tail) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // ---- Stage: metadata FIFO ----
  logic fifo_pop, fifo_full, push_ok, drop;
  assign fifo_pop  = (fcnt_q != '0) && meta_ready;
  assign fifo_full = (fcnt_q == CNT_FULL);
  // A full FIFO that pops on the same edge still has room for the push.
  assign push_ok   = commit && (!fifo_full || fifo_pop);
  assign drop      = commit && fifo_full && !fifo_pop;

  // Datapath storage carries no reset; every use is preceded by a load.
  always_ff @(posedge clk) begin
    if (ld_hit) hit_q <= pkt_in[127];
    if (ld1)    l1_q  <= pkt_in[127:0];
    if (ld2)    l2_q  <= pkt_in[127:0];
    if (ld3)    l3_q  <= pkt_in[127:0];
    if (push_ok) mem_q[wp_q] <= meta_word;
  end

  // ---- Stage: registered outputs, control and counters ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pkt_out_wr_q <= 1'b0;
      pkt_out_q    <= '0;
      meta_vld_q   <= 1'b0;
      meta_q       <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      fcnt_q       <= '0;
      cnt_pkt_q    <= '0;
      cnt_drop_q   <= '0;
      cnt_malf_q   <= '0;
    end else begin
      state_q      <= state_d;
      pkt_out_wr_q <= pkt_in_wr;
      pkt_out_q    <= pkt_in;
      meta_vld_q   <= fifo_pop;
      if (fifo_pop) begin
        meta_q <= mem_q[rp_q];
        rp_q   <= rp_q + PTR_ONE;
      end
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (push_ok && !fifo_pop)      fcnt_q <= fcnt_q + CNT_ONE;
      else if (!push_ok && fifo_pop) fcnt_q <= fcnt_q - CNT_ONE;
      if (commit)    cnt_pkt_q  <= sat_inc32(cnt_pkt_q);
      if (drop)      cnt_drop_q <= sat_inc16(cnt_drop_q);
      if (malformed) cnt_malf_q <= sat_inc16(cnt_malf_q);
    end
  end

  assign pkt_out_wr         = pkt_out_wr_q;
  assign pkt_out            = pkt_out_q;
  assign metadata_out_valid = meta_vld_q;
  assign metadata_out       = meta_q;
  assign cnt_pkt            = cnt_pkt_q;
  assign cnt_meta_drop      = cnt_drop_q;
  assign cnt_malformed      = cnt_malf_q;

  logic unused_bits;
  assign unused_bits = ^{pkt_in[131:128], doff_b[3:0], vihl_b[7:4]};

endmodule

// File: tb/tb_fast_meta_parser.sv
module tb_fast_meta_parser;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pkt_in_wr = 1'b0;
  logic [133:0] pkt_in = '0;
  logic         meta_ready = 1'b1;
  logic         pkt_out_wr;
  logic [133:0] pkt_out;
  logic         metadata_out_valid;
  logic [208:0] metadata_out;
  logic [31:0]  cnt_pkt;
  logic [15:0]  cnt_meta_drop;
  logic [15:0]  cnt_malformed;

  fast_meta_parser dut (
    .clk(clk), .reset(reset), .pkt_in_wr(pkt_in_wr), .pkt_in(pkt_in),
    .pkt_out_wr(pkt_out_wr), .pkt_out(pkt_out), .meta_ready(meta_ready),
    .metadata_out_valid(metadata_out_valid), .metadata_out(metadata_out),
    .cnt_pkt(cnt_pkt), .cnt_meta_drop(cnt_meta_drop),
    .cnt_malformed(cnt_malformed)
  );

  always #5 clk = ~clk;

  localparam logic [208:0] SYN_LIT = {1'b1, 32'h0A000001, 32'h0A000002,
    16'h04D2, 16'h0050, 8'h06, 16'h0000, 8'h02, 32'h11111111, 32'h0, 16'hFFFF};

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_pkt = 0, exp_drop = 0, exp_malf = 0;
  int line4_cyc = 0;
  int nstrobe = 0;
  int strobe_cyc[$];
  int s0;
  logic [208:0] last_meta = '0;
  logic [208:0] exp_q[$];
  logic [7:0]   fr[80];

  task automatic chk(input string nm, input logic [208:0] act, input logic [208:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Ethernet/IPv4/L4 frame builder; unused bytes get a nonzero filler.
  task automatic mk_frame(input bit vlan, input logic [7:0] vihl, input logic [15:0] et,
                          input logic [7:0] proto, input logic [15:0] total,
                          input logic [15:0] sp, input logic [15:0] dp,
                          input logic [31:0] sq, input logic [31:0] ak,
                          input logic [7:0] fl, input logic [15:0] wn);
    int o;
    for (int i = 0; i < 80; i++) fr[i] = 8'(i * 7 + 3);
    o = 0;
    if (vlan) begin
      fr[12] = 8'h81; fr[13] = 8'h00; fr[14] = 8'h00; fr[15] = 8'h05;
      o = 4;
    end
    {fr[12+o], fr[13+o]} = et;
    fr[14+o] = vihl;
    {fr[16+o], fr[17+o]} = total;
    fr[23+o] = proto;
    {fr[26+o], fr[27+o], fr[28+o], fr[29+o]} = 32'h0A000001;
    {fr[30+o], fr[31+o], fr[32+o], fr[33+o]} = 32'h0A000002;
    {fr[34+o], fr[35+o]} = sp;
    {fr[36+o], fr[37+o]} = dp;
    {fr[38+o], fr[39+o], fr[40+o], fr[41+o]} = sq;
    {fr[42+o], fr[43+o], fr[44+o], fr[45+o]} = ak;
    fr[46+o] = 8'h50;
    fr[47+o] = fl;
    {fr[48+o], fr[49+o]} = wn;
  endtask

  // Expected metadata straight from the frame bytes.
  function automatic logic [208:0] model_meta(input bit hit, output bit ok);
    int o;
    logic [15:0] et, tot, clen, sp, dp, wn;
    logic [7:0]  pr, fl;
    logic [31:0] s, d, sq, ak;
    o  = 0;
    et = {fr[12], fr[13]};
`ifdef FAST_PARSER_VLAN_EN
    if (et == 16'h8100) begin
      o  = 4;
      et = {fr[16], fr[17]};
    end
`endif
    ok  = (et == 16'h0800) && (fr[14+o][3:0] == 4'd5);
    tot = {fr[16+o], fr[17+o]};
    pr  = fr[23+o];
    s   = {fr[26+o], fr[27+o], fr[28+o], fr[29+o]};
    d   = {fr[30+o], fr[31+o], fr[32+o], fr[33+o]};
    sp  = {fr[34+o], fr[35+o]};
    dp  = {fr[36+o], fr[37+o]};
    sq  = {fr[38+o], fr[39+o], fr[40+o], fr[41+o]};
    ak  = {fr[42+o], fr[43+o], fr[44+o], fr[45+o]};
    fl  = fr[47+o];
    wn  = {fr[48+o], fr[49+o]};
    if (pr == 8'd6) begin
      clen = tot - 16'd20 - 16'(int'(fr[46+o][7:4]) * 4);
    end else if (pr == 8'd17) begin
      clen = tot - 16'd28;
      fl = '0; sq = '0; ak = '0; wn = '0;
    end else begin
      clen = tot - 16'd20;
      sp = '0; dp = '0; fl = '0; sq = '0; ak = '0; wn = '0;
    end
    return {hit, s, d, sp, dp, pr, clen, fl, sq, ak, wn};
  endfunction

  task automatic model_commit(input bit hit);
    bit ok;
    logic [208:0] w;
    w = model_meta(hit, ok);
    if (ok) begin
      exp_pkt++;
      if (exp_q.size() >= 4 && !meta_ready) exp_drop++;
      else exp_q.push_back(w);
    end
  endtask

  function automatic logic [127:0] line_of(input int n);
    logic [127:0] v;
    for (int b = 0; b < 16; b++) v[127-8*b -: 8] = fr[16*(n-1)+b];
    return v;
  endfunction

  task automatic send_line(input logic [1:0] flag, input logic [127:0] data);
    @(negedge clk);
    pkt_in_wr = 1'b1;
    pkt_in    = {flag, 4'hF, data};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pkt_in_wr = 1'b0;
      pkt_in    = '0;
    end
  endtask

  // Head + nl Ethernet lines, the last flagged tail. intr: the head aborts a
  // parse already in progress.
  task automatic send_frame(input bit hit, input int nl, input bit gap, input bit intr);
    send_line(2'b01, {hit, 127'd0});
    if (intr) exp_malf++;
    for (int i = 1; i <= nl; i++) begin
      if (gap) idle(2);
      send_line((i == nl) ? 2'b10 : 2'b11, line_of(i));
      if (i == 4) begin
        line4_cyc = cyc;
        model_commit(hit);
      end else if (i == nl && i < 4) begin
        exp_malf++;
      end
    end
    idle(1);
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    logic         e_wr;
    logic [133:0] e_pkt;
    logic         r;
    e_wr  = pkt_in_wr;
    e_pkt = pkt_in;
    r     = reset;
    cyc++;
    #1;
    if (!r) begin
      chk("rst_pkt_out_wr", 209'(pkt_out_wr), 209'(0));
      chk("rst_pkt_out", 209'(pkt_out), 209'(0));
      chk("rst_meta_valid", 209'(metadata_out_valid), 209'(0));
      chk("rst_meta", metadata_out, 209'(0));
    end else begin
      chk("fwd_wr", 209'(pkt_out_wr), 209'(e_wr));
      chk("fwd_data", 209'(pkt_out), 209'(e_pkt));
    end
    chk("cnt_pkt", 209'(cnt_pkt), 209'(exp_pkt));
    chk("cnt_meta_drop", 209'(cnt_meta_drop), 209'(exp_drop));
    chk("cnt_malformed", 209'(cnt_malformed), 209'(exp_malf));
    if (metadata_out_valid) begin
      nstrobe++;
      strobe_cyc.push_back(cyc);
      last_meta = metadata_out;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL meta_unexpected actual=%h required=none", metadata_out);
      end else begin
        chk("meta_word", metadata_out, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cnt_pkt", 209'(cnt_pkt), 209'(0));
    chk("reset_meta_valid", 209'(metadata_out_valid), 209'(0));
    reset = 1'b1;
    idle(2);

    // TCP SYN with hand-computed word and two-cycle latency
    mk_frame(0, 8'h45, 16'h0800, 8'd6, 16'd40, 16'd1234, 16'd80,
             32'h11111111, 32'h0, 8'h02, 16'hFFFF);
    s0 = nstrobe;
    send_frame(1, 4, 0, 0);
    idle(4);
    chk("syn_strobes", 209'(nstrobe - s0), 209'(1));
    chk("syn_word", last_meta, SYN_LIT);
    chk("syn_latency", 209'(strobe_cyc[s0] - line4_cyc), 209'(2));
    chk("syn_cnt_pkt", 209'(cnt_pkt), 209'(1));

    // UDP, total 100, five lines
    mk_frame(0, 8'h45, 16'h0800, 8'd17, 16'd100, 16'h1000, 16'h0035,
             32'h33333333, 32'h44444444, 8'h18, 16'h1234);
    send_frame(0, 5, 0, 0);
    idle(4);
    chk("udp_clen", 209'(last_meta[103:88]), 209'(72));
    chk("udp_tail_zero", 209'(last_meta[87:0]), 209'(0));
    chk("udp_ports", 209'(last_meta[143:112]), 209'(32'h10000035));

    // ARP: forwarded only
    mk_frame(0, 8'h45, 16'h0806, 8'd6, 16'd40, 16'd1, 16'd2,
             32'h5, 32'h6, 8'h10, 16'h10);
    s0 = nstrobe;
    send_frame(1, 4, 0, 0);
    idle(4);
    chk("arp_no_meta", 209'(nstrobe - s0), 209'(0));
    chk("arp_cnt_pkt", 209'(cnt_pkt), 209'(2));

    // ICMP: ports and TCP fields zero, length total-20
    mk_frame(0, 8'h45, 16'h0800, 8'd1, 16'd84, 16'h0800, 16'h0001,
             32'h77777777, 32'h88888888, 8'hFF, 16'hABCD);
    send_frame(1, 4, 0, 0);
    idle(4);
    chk("icmp_clen", 209'(last_meta[103:88]), 209'(64));
    chk("icmp_ports", 209'(last_meta[143:112]), 209'(0));

    // IHL 6: nothing
    mk_frame(0, 8'h46, 16'h0800, 8'd6, 16'd44, 16'd1, 16'd2,
             32'h9, 32'h9, 8'h10, 16'h10);
    s0 = nstrobe;
    send_frame(1, 4, 0, 0);
    idle(4);
    chk("ihl6_no_meta", 209'(nstrobe - s0), 209'(0));
    chk("ihl6_cnt_pkt", 209'(cnt_pkt), 209'(3));

    // Idle gaps between lines
    mk_frame(0, 8'h45, 16'h0800, 8'd6, 16'd40, 16'd1234, 16'd80,
             32'h11111111, 32'h0, 8'h02, 16'hFFFF);
    send_frame(1, 4, 1, 0);
    idle(4);
    chk("gap_word", last_meta, SYN_LIT);

    // Core stalled: 4 queued, 2 dropped, then a back-to-back burst
    @(negedge clk);
    meta_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      mk_frame(0, 8'h45, 16'h0800, 8'd6, 16'd60, 16'd1000, 16'd80,
               32'(k), 32'h0, 8'h10, 16'h0100);
      send_frame(0, 4, 0, 0);
    end
    s0 = nstrobe;
    idle(3);
    chk("stall_drop", 209'(cnt_meta_drop), 209'(2));
    chk("stall_no_strobe", 209'(nstrobe - s0), 209'(0));
    @(negedge clk);
    meta_ready = 1'b1;
    idle(8);
    chk("burst_count", 209'(nstrobe - s0), 209'(4));
    chk("burst_back_to_back", 209'(strobe_cyc[s0+3] - strobe_cyc[s0]), 209'(3));
    chk("burst_last_seq", 209'(last_meta[79:48]), 209'(4));
    chk("burst_clen", 209'(last_meta[103:88]), 209'(20));

    // Truncated packet, then a head arriving in L3, then a good packet
    mk_frame(0, 8'h45, 16'h0800, 8'd6, 16'd40, 16'd1234, 16'd80,
             32'h11111111, 32'h0, 8'h02, 16'hFFFF);
    s0 = nstrobe;
    send_frame(1, 2, 0, 0);
    send_line(2'b01, {1'b1, 127'd0});
    send_line(2'b11, line_of(1));
    send_line(2'b11, line_of(2));
    send_frame(1, 4, 0, 1);
    idle(4);
    chk("malf_count", 209'(cnt_malformed), 209'(2));
    chk("malf_one_strobe", 209'(nstrobe - s0), 209'(1));
    chk("malf_recover_word", last_meta, SYN_LIT);

    // Reset while in L3
    s0 = nstrobe;
    send_line(2'b01, {1'b1, 127'd0});
    send_line(2'b11, line_of(1));
    send_line(2'b11, line_of(2));
    @(negedge clk);
    pkt_in_wr = 1'b0;
    pkt_in    = '0;
    reset     = 1'b0;
    exp_pkt = 0; exp_drop = 0; exp_malf = 0;
    exp_q.delete();
    #1;
    chk("midrst_cnt_pkt", 209'(cnt_pkt), 209'(0));
    chk("midrst_cnt_malf", 209'(cnt_malformed), 209'(0));
    chk("midrst_pkt_out_wr", 209'(pkt_out_wr), 209'(0));
    @(negedge clk);
    reset = 1'b1;
    send_line(2'b11, line_of(3));
    send_line(2'b10, line_of(4));
    idle(4);
    chk("midrst_no_meta", 209'(nstrobe - s0), 209'(0));
    chk("midrst_cnt_after", 209'(cnt_pkt), 209'(0));

    // 802.1Q-tagged TCP SYN
    mk_frame(1, 8'h45, 16'h0800, 8'd6, 16'd40, 16'd1234, 16'd80,
             32'h11111111, 32'h0, 8'h02, 16'hFFFF);
    s0 = nstrobe;
    send_frame(1, 4, 0, 0);
    idle(4);
`ifdef FAST_PARSER_VLAN_EN
    chk("vlan_strobes", 209'(nstrobe - s0), 209'(1));
    chk("vlan_word", last_meta, SYN_LIT);
    chk("vlan_cnt_pkt", 209'(cnt_pkt), 209'(1));
`else
    chk("vlan_strobes", 209'(nstrobe - s0), 209'(0));
    chk("vlan_cnt_pkt", 209'(cnt_pkt), 209'(0));
`endif

    idle(3);
    chk("meta_pending", 209'(exp_q.size()), 209'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
